// File: rtl/dbg_link_master.sv
// rtl/dbg_link_master.sv - MIPS debug-link initiator: one command in, one response out (SCLK/CS/MOSI/step/continue)
// Optional second MISO capture with mismatch flag: define DBG_LINK_DOUBLE_SAMPLE_EN.
module dbg_link_master #(
    parameter int NB_BITS   = 32,
    parameter int NB_MOSI   = 25,
    parameter int NB_CS     = 4,
    parameter int SCLK_HALF = 4,
    parameter int SETUP_CYC = 2,
    parameter int STEP_CYC  = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [1:0]         i_cmd,
    input  logic [NB_CS-1:0]   i_cs,
    input  logic [NB_MOSI-1:0] i_wdata,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    output logic [NB_BITS-1:0] o_rsp_data,
    output logic               o_rsp_err,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    input  logic [NB_BITS-1:0] i_MISO,
    output logic [NB_MOSI-1:0] o_MOSI,
    output logic [NB_CS-1:0]   o_SPI_cs,
    output logic               o_SCLK,
    output logic               o_valid,
    output logic               o_continue
);

    localparam logic [1:0] CMD_XFER     = 2'd0;
    localparam logic [1:0] CMD_STEP     = 2'd1;
    localparam logic [1:0] CMD_CONT_SET = 2'd2;
    localparam logic [1:0] CMD_CONT_CLR = 2'd3;

    localparam int CNT_MAX_A = (SETUP_CYC > SCLK_HALF) ? SETUP_CYC : SCLK_HALF;
    localparam int CNT_MAX   = (CNT_MAX_A > STEP_CYC) ? CNT_MAX_A : STEP_CYC;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCLK_HI,
        ST_SCLK_LO,
        ST_SAMPLE,
        ST_SAMPLE2,
        ST_STEP_HI,
        ST_STEP_LO,
        ST_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NB_CS-1:0]   cs_q, cs_d;
    logic [NB_MOSI-1:0] mosi_q, mosi_d;
    logic               cont_q, cont_d;
    logic               sclk_q, sclk_d;
    logic               valid_q, valid_d;
    logic [NB_BITS-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               req_ready_q, req_ready_d;
`ifdef DBG_LINK_DOUBLE_SAMPLE_EN
    logic [NB_BITS-1:0] cap_q, cap_d;
`endif

    logic accept;
    logic cnt_zero;

    assign accept   = i_req_valid && req_ready_q;
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Each timed state loads cnt with (duration - 1) on entry and leaves when it reaches zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (i_cmd)
                        CMD_XFER: begin
                            state_d = ST_SETUP;
                            cnt_d   = CNT_W'(SETUP_CYC - 1);
                        end
                        CMD_STEP: begin
                            state_d = ST_STEP_HI;
                            cnt_d   = CNT_W'(STEP_CYC - 1);
                        end
                        default: state_d = ST_SAMPLE;
                    endcase
                end
            end
            ST_SETUP, ST_SCLK_HI, ST_SCLK_LO, ST_STEP_HI, ST_STEP_LO, ST_SAMPLE2: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    case (state_q)
                        ST_SETUP: begin
                            state_d = ST_SCLK_HI;
                            cnt_d   = CNT_W'(SCLK_HALF - 1);
                        end
                        ST_SCLK_HI: begin
                            state_d = ST_SCLK_LO;
                            cnt_d   = CNT_W'(SCLK_HALF - 1);
                        end
                        ST_STEP_HI: begin
                            state_d = ST_STEP_LO;
                            cnt_d   = CNT_W'(STEP_CYC - 1);
                        end
                        ST_SAMPLE2: state_d = ST_RESP;
                        default:    state_d = ST_SAMPLE;
                    endcase
                end
            end
            ST_SAMPLE: begin
`ifdef DBG_LINK_DOUBLE_SAMPLE_EN
                state_d = ST_SAMPLE2;
                cnt_d   = CNT_W'(SCLK_HALF - 1);
`else
                state_d = ST_RESP;
`endif
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        cs_d        = cs_q;
        mosi_d      = mosi_q;
        cont_d      = cont_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        sclk_d      = (state_d == ST_SCLK_HI);
        valid_d     = (state_d == ST_STEP_HI);
        rsp_valid_d = (state_d == ST_RESP);
        req_ready_d = (state_d == ST_IDLE);
        if (state_q == ST_IDLE && accept) begin
            case (i_cmd)
                CMD_XFER: begin
                    cs_d   = i_cs;
                    mosi_d = i_wdata;
                end
                CMD_CONT_SET: cont_d = 1'b1;
                CMD_CONT_CLR: cont_d = 1'b0;
                default: ;
            endcase
        end
`ifdef DBG_LINK_DOUBLE_SAMPLE_EN
        cap_d = cap_q;
        if (state_q == ST_SAMPLE) begin
            cap_d = i_MISO;
        end
        if (state_q == ST_SAMPLE2 && cnt_zero) begin
            rsp_data_d = i_MISO;
            rsp_err_d  = (i_MISO != cap_q);
        end
`else
        if (state_q == ST_SAMPLE) begin
            rsp_data_d = i_MISO;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q       <= '0;
            cs_q        <= '0;
            mosi_q      <= '0;
            cont_q      <= 1'b0;
            sclk_q      <= 1'b0;
            valid_q     <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
            cont_q      <= cont_d;
            sclk_q      <= sclk_d;
            valid_q     <= valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
        end
    end

`ifdef DBG_LINK_DOUBLE_SAMPLE_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cap_q <= '0;
        end else begin
            cap_q <= cap_d;
        end
    end
`endif

    assign o_req_ready = req_ready_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_MOSI      = mosi_q;
    assign o_SPI_cs    = cs_q;
    assign o_SCLK      = sclk_q;
    assign o_valid     = valid_q;
    assign o_continue  = cont_q;

endmodule

// File: tb/tb_dbg_link_master.sv
// tb/tb_dbg_link_master.sv - directed bench for dbg_link_master with a timeline-based reference model
module tb_dbg_link_master;

    localparam int S  = 2;
    localparam int SH = 4;
    localparam int ST = 4;
`ifdef DBG_LINK_DOUBLE_SAMPLE_EN
    localparam int EXTRA = 4;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cmd;
    logic [3:0]  cs;
    logic [24:0] wdata;
    logic        req_valid;
    logic        rsp_ready;
    logic [31:0] miso;

    logic        o_req_ready;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;
    logic        o_rsp_valid;
    logic [24:0] o_MOSI;
    logic [3:0]  o_SPI_cs;
    logic        o_SCLK;
    logic        o_valid;
    logic        o_continue;

    dbg_link_master dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_cmd      (cmd),
        .i_cs       (cs),
        .i_wdata    (wdata),
        .i_req_valid(req_valid),
        .o_req_ready(o_req_ready),
        .o_rsp_data (o_rsp_data),
        .o_rsp_err  (o_rsp_err),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(rsp_ready),
        .i_MISO     (miso),
        .o_MOSI     (o_MOSI),
        .o_SPI_cs   (o_SPI_cs),
        .o_SCLK     (o_SCLK),
        .o_valid    (o_valid),
        .o_continue (o_continue)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every command is a timeline measured in edges from its accept edge.
    int          cyc = 0;
    int          m_acc = 0;
    int          m_lat = 0;
    bit          m_busy = 1'b0;
    bit          m_ready = 1'b0;
    logic [1:0]  m_cmd = 2'd0;
    logic [3:0]  m_cs = 4'h0;
    logic [24:0] m_mosi = 25'h0;
    bit          m_cont = 1'b0;
    logic [31:0] m_data = 32'h0;
    logic [31:0] m_cap1 = 32'h0;
    bit          m_err = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_cont  = 1'b0;
            m_cs    = 4'h0;
            m_mosi  = 25'h0;
            m_data  = 32'h0;
            m_cap1  = 32'h0;
            m_err   = 1'b0;
        end else begin
            cyc++;
            if (m_busy) begin
`ifdef DBG_LINK_DOUBLE_SAMPLE_EN
                if (cyc - m_acc == m_lat - 1 - SH) m_cap1 = miso;
`endif
                if (cyc - m_acc == m_lat - 1) begin
                    m_data = miso;
`ifdef DBG_LINK_DOUBLE_SAMPLE_EN
                    m_err = (miso != m_cap1);
`endif
                end
                if (cyc - m_acc >= m_lat && rsp_ready) m_busy = 1'b0;
            end else if (m_ready && req_valid) begin
                m_busy = 1'b1;
                m_acc  = cyc;
                m_cmd  = cmd;
                case (cmd)
                    2'd0: begin
                        m_lat  = S + 2 * SH + 2 + EXTRA;
                        m_cs   = cs;
                        m_mosi = wdata;
                    end
                    2'd1: m_lat = 2 * ST + 2 + EXTRA;
                    2'd2: begin m_lat = 2 + EXTRA; m_cont = 1'b1; end
                    default: begin m_lat = 2 + EXTRA; m_cont = 1'b0; end
                endcase
            end
            m_ready = !m_busy;
        end
    end

    // Cycle compare against the model, sampled mid-cycle.
    initial forever begin
        int rel;
        @(negedge clk);
        rel = cyc - m_acc;
        chk("req_ready", 64'(o_req_ready), 64'(m_ready));
        chk("sclk", 64'(o_SCLK), 64'(m_busy && m_cmd == 2'd0 && rel >= S && rel < S + SH));
        chk("step_valid", 64'(o_valid), 64'(m_busy && m_cmd == 2'd1 && rel < ST));
        chk("rsp_valid", 64'(o_rsp_valid), 64'(m_busy && rel >= m_lat - 1));
        chk("rsp_data", 64'(o_rsp_data), 64'(m_data));
        chk("rsp_err", 64'(o_rsp_err), 64'(m_err));
        chk("spi_cs", 64'(o_SPI_cs), 64'(m_cs));
        chk("mosi", 64'(o_MOSI), 64'(m_mosi));
        chk("continue", 64'(o_continue), 64'(m_cont));
        chk("sclk_step_overlap", 64'(o_SCLK & o_valid), 64'd0);
    end

    // Waveform statistics used by the hand-computed checks.
    int sclk_hi = 0;
    int sclk_first = -1;
    int v_rises = 0;
    int hi_run = 0;
    int low_run = 0;
    int min_gap = 1000;
    int hi_lens[$];
    bit prev_v = 1'b0;

    initial forever begin
        @(negedge clk);
        if (o_SCLK) begin
            if (sclk_first < 0) sclk_first = cyc;
            sclk_hi++;
        end
        if (o_valid) begin
            if (!prev_v) begin
                if (v_rises > 0 && low_run < min_gap) min_gap = low_run;
                v_rises++;
                hi_run = 0;
            end
            hi_run++;
        end else begin
            if (prev_v) begin
                hi_lens.push_back(hi_run);
                low_run = 0;
            end
            low_run++;
        end
        prev_v = o_valid;
    end

    task automatic clear_stats();
        sclk_hi    = 0;
        sclk_first = -1;
        v_rises    = 0;
        min_gap    = 1000;
        hi_lens.delete();
    endtask

    task automatic run_cmd(input logic [1:0] c, input logic [3:0] c_cs, input logic [24:0] wd,
                           input logic [31:0] m0, input logic [31:0] m1, input int sw_rel,
                           output int lat);
        int n;
        int rel;
        miso      = m0;
        cmd       = c;
        cs        = c_cs;
        wdata     = wd;
        req_valid = 1'b1;
        lat       = -1;
        n         = 0;
        @(negedge clk);
        while (!o_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 64'(o_req_ready), 64'd1);
        if (!o_req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rel = 0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (o_rsp_valid) begin
                lat = rel + 1;
                break;
            end
            @(posedge clk);
            #1;
            rel++;
            if (rel == sw_rel) miso = m1;
        end
        chk("rsp_timeout", 64'(o_rsp_valid), 64'd1);
    endtask

    initial begin
        int lat;
        int cnt;
        int n;
        cmd       = 2'd0;
        cs        = 4'h0;
        wdata     = 25'h0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        miso      = 32'h0;

        #12;
        chk("reset_req_ready", 64'(o_req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("reset_continue", 64'(o_continue), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_first_edge", 64'(o_req_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_first_edge", 64'(o_req_ready), 64'd1);

        // XFER with default timing
        @(posedge clk); #1;
        clear_stats();
        run_cmd(2'd0, 4'h3, 25'h1ABCDEF, 32'hDEADBEEF, 32'hDEADBEEF, -1, lat);
        chk("xfer_latency", 64'(lat), 64'(12 + EXTRA));
        chk("xfer_data", 64'(o_rsp_data), 64'hDEADBEEF);
        chk("xfer_cs", 64'(o_SPI_cs), 64'h3);
        chk("xfer_mosi", 64'(o_MOSI), 64'h1ABCDEF);
        chk("xfer_sclk_cycles", 64'(sclk_hi), 64'd4);
        chk("xfer_sclk_start", 64'(sclk_first - m_acc), 64'd2);

        // Two back-to-back steps
        @(posedge clk); #1;
        clear_stats();
        run_cmd(2'd1, 4'hF, 25'h1FFFFFF, 32'h0000A5A5, 32'h0000A5A5, -1, lat);
        chk("step1_latency", 64'(lat), 64'(10 + EXTRA));
        chk("step1_data", 64'(o_rsp_data), 64'h0000A5A5);
        run_cmd(2'd1, 4'hF, 25'h1FFFFFF, 32'h00005A5A, 32'h00005A5A, -1, lat);
        chk("step2_latency", 64'(lat), 64'(10 + EXTRA));
        chk("step_rises", 64'(v_rises), 64'd2);
        chk("step_high_count", 64'(hi_lens.size()), 64'd2);
        if (hi_lens.size() == 2) begin
            chk("step1_high_len", 64'(hi_lens[0]), 64'd4);
            chk("step2_high_len", 64'(hi_lens[1]), 64'd4);
        end
        chk("step_low_gap_ge4", 64'(min_gap >= 4), 64'd1);
        chk("step_no_sclk", 64'(sclk_hi), 64'd0);
        chk("step_keeps_cs", 64'(o_SPI_cs), 64'h3);

        // Continue set / clear
        run_cmd(2'd2, 4'h0, 25'h0, 32'h11111111, 32'h11111111, -1, lat);
        chk("cont_set_latency", 64'(lat), 64'(2 + EXTRA));
        chk("cont_set_level", 64'(o_continue), 64'd1);
        chk("cont_keeps_mosi", 64'(o_MOSI), 64'h1ABCDEF);
        chk("cont_keeps_cs", 64'(o_SPI_cs), 64'h3);
        repeat (5) @(negedge clk);
        chk("cont_held", 64'(o_continue), 64'd1);
        run_cmd(2'd3, 4'h0, 25'h0, 32'h22222222, 32'h22222222, -1, lat);
        chk("cont_clr_latency", 64'(lat), 64'(2 + EXTRA));
        chk("cont_clr_level", 64'(o_continue), 64'd0);
        chk("cont_clr_data", 64'(o_rsp_data), 64'h22222222);

        // Response backpressure with an ignored request
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        run_cmd(2'd0, 4'hA, 25'h0123456, 32'h12345678, 32'h12345678, -1, lat);
        @(posedge clk); #1;
        miso      = 32'hFFFF0000;
        cmd       = 2'd2;
        req_valid = 1'b1;
        repeat (10) @(negedge clk);
        chk("bp_rsp_valid", 64'(o_rsp_valid), 64'd1);
        chk("bp_rsp_data", 64'(o_rsp_data), 64'h12345678);
        chk("bp_req_ready", 64'(o_req_ready), 64'd0);
        chk("bp_ignored_cont", 64'(o_continue), 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_rsp_valid && rsp_ready) cnt++;
        end
        chk("bp_single_handshake", 64'(cnt), 64'd1);
        chk("bp_ready_back", 64'(o_req_ready), 64'd1);

        // MISO changing between the two capture points, then stable
        run_cmd(2'd0, 4'h5, 25'h0AAAAAA, 32'h1, 32'h2, 12, lat);
`ifdef DBG_LINK_DOUBLE_SAMPLE_EN
        chk("dbl_changing_data", 64'(o_rsp_data), 64'h2);
        chk("dbl_changing_err", 64'(o_rsp_err), 64'd1);
`else
        chk("single_changing_data", 64'(o_rsp_data), 64'h1);
        chk("single_changing_err", 64'(o_rsp_err), 64'd0);
`endif
        run_cmd(2'd0, 4'h6, 25'h0555555, 32'h7, 32'h7, -1, lat);
        chk("stable_data", 64'(o_rsp_data), 64'h7);
        chk("stable_err", 64'(o_rsp_err), 64'd0);

        // Asynchronous reset in the middle of a transfer
        run_cmd(2'd2, 4'h0, 25'h0, 32'h0, 32'h0, -1, lat);
        @(posedge clk); #1;
        cmd       = 2'd0;
        cs        = 4'h9;
        wdata     = 25'h155AA55;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!o_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_accept", 64'(o_req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!o_SCLK && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_sclk_reached", 64'(o_SCLK), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sclk", 64'(o_SCLK), 64'd0);
        chk("async_rst_cs", 64'(o_SPI_cs), 64'd0);
        chk("async_rst_mosi", 64'(o_MOSI), 64'd0);
        chk("async_rst_continue", 64'(o_continue), 64'd0);
        chk("async_rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("async_rst_rsp_data", 64'(o_rsp_data), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready_before_edge", 64'(o_req_ready), 64'd0);
        @(negedge clk);
        chk("rel_ready_after_edge", 64'(o_req_ready), 64'd1);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_rsp_valid) cnt++;
        end
        chk("no_rsp_after_abort", 64'(cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
